// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the datapath it drives.
// master = sequencer side, slave = datapath/memory side.
interface control_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic        incPC;
    logic        read;
    logic        write;
    logic [3:0]  reg_addr;
    logic [4:0]  BusDataSelect;
    logic [4:0]  alu_op;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  start, ir, mem_ready,
        output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
        output incPC, read, write, reg_addr, BusDataSelect, alu_op, halted, state
    );

    modport slave (
        output start, ir, mem_ready,
        input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
        input  incPC, read, write, reg_addr, BusDataSelect, alu_op, halted, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch T0-T2, decode T3, execute T4-T7, HALT.
// Optional MEM_WAIT_EN stalls memory states until mem_ready is seen.
module control_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] SEL_HI   = 5'd16;
    localparam logic [4:0] SEL_LO   = 5'd17;
    localparam logic [4:0] SEL_ZHI  = 5'd18;
    localparam logic [4:0] SEL_ZLO  = 5'd19;
    localparam logic [4:0] SEL_PC   = 5'd20;
    localparam logic [4:0] SEL_MDR  = 5'd21;
    localparam logic [4:0] SEL_CIMM = 5'd22;

    state_t      state_q, state_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_md, is_ld, is_st, is_halt, is_exec;
    logic       mem_ok;
    logic       unused_bits;

    assign opcode = bus.ir[31:27];
    assign ra     = bus.ir[26:23];
    assign rb     = bus.ir[22:19];
    assign rc     = bus.ir[18:15];

    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_md   = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_halt = (opcode == OP_HALT);
    // Unlisted opcodes fall out of is_exec and therefore behave as nop.
    assign is_exec = is_alu || is_md || is_ld || is_st;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // Low IR bits hold the immediate, which the datapath extracts itself.
    assign unused_bits = ^{bus.ir[14:0], bus.mem_ready};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cyc_cnt_d         = cyc_cnt_q;
        bus.e_PC          = 1'b0;
        bus.e_IR          = 1'b0;
        bus.e_Y           = 1'b0;
        bus.e_Z           = 1'b0;
        bus.e_HI          = 1'b0;
        bus.e_LO          = 1'b0;
        bus.e_MDR         = 1'b0;
        bus.e_MAR         = 1'b0;
        bus.e_GP          = 1'b0;
        bus.incPC         = 1'b0;
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.reg_addr      = 4'd0;
        bus.BusDataSelect = 5'd0;
        bus.alu_op        = 5'd0;
        bus.halted        = 1'b0;
        bus.state         = state_q;

        if (state_q != S_IDLE && state_q != S_HALT) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_T0;
            end
            S_T0: begin
                bus.BusDataSelect = SEL_PC;
                bus.e_MAR         = 1'b1;
                bus.incPC         = 1'b1;
                state_d           = S_T1;
            end
            S_T1: begin
                bus.read  = 1'b1;
                bus.e_MDR = 1'b1;
                if (mem_ok) state_d = S_T2;
            end
            S_T2: begin
                bus.BusDataSelect = SEL_MDR;
                bus.e_IR          = 1'b1;
                state_d           = S_T3;
            end
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_exec) begin
                    bus.BusDataSelect = {1'b0, rb};
                    bus.e_Y           = 1'b1;
                    state_d           = S_T4;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                bus.e_Z = 1'b1;
                if (is_ld || is_st) begin
                    bus.BusDataSelect = SEL_CIMM;
                    bus.alu_op        = OP_ADD;
                end else begin
                    bus.BusDataSelect = {1'b0, rc};
                    bus.alu_op        = opcode;
                end
                state_d = S_T5;
            end
            S_T5: begin
                bus.BusDataSelect = SEL_ZLO;
                if (is_alu) begin
                    bus.reg_addr = ra;
                    bus.e_GP     = 1'b1;
                    state_d      = S_T0;
                end else if (is_md) begin
                    bus.e_LO = 1'b1;
                    state_d  = S_T6;
                end else begin
                    bus.e_MAR = 1'b1;
                    state_d   = S_T6;
                end
            end
            S_T6: begin
                if (is_md) begin
                    bus.BusDataSelect = SEL_ZHI;
                    bus.e_HI          = 1'b1;
                    state_d           = S_T0;
                end else if (is_ld) begin
                    bus.read  = 1'b1;
                    bus.e_MDR = 1'b1;
                    if (mem_ok) state_d = S_T7;
                end else begin
                    bus.BusDataSelect = {1'b0, ra};
                    bus.e_MDR         = 1'b1;
                    state_d           = S_T7;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    bus.BusDataSelect = SEL_MDR;
                    bus.reg_addr      = ra;
                    bus.e_GP          = 1'b1;
                    state_d           = S_T0;
                end else begin
                    bus.write = 1'b1;
                    if (mem_ok) state_d = S_T0;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction step plan built from
// the instruction set rules is replayed against the DUT cycle by cycle.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic clear;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] state;
        logic       e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar, e_gp;
        logic       incpc, rd, wr;
        logic [3:0] reg_addr;
        logic [4:0] bds;
        logic [4:0] alu_op;
        logic       halted;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  mem;
    } step_t;

    step_t       plan_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t observe();
        outs_t o;
        o.state    = bus.state;
        o.e_pc     = bus.e_PC;
        o.e_ir     = bus.e_IR;
        o.e_y      = bus.e_Y;
        o.e_z      = bus.e_Z;
        o.e_hi     = bus.e_HI;
        o.e_lo     = bus.e_LO;
        o.e_mdr    = bus.e_MDR;
        o.e_mar    = bus.e_MAR;
        o.e_gp     = bus.e_GP;
        o.incpc    = bus.incPC;
        o.rd       = bus.read;
        o.wr       = bus.write;
        o.reg_addr = bus.reg_addr;
        o.bds      = bus.BusDataSelect;
        o.alu_op   = bus.alu_op;
        o.halted   = bus.halted;
        return o;
    endfunction

    function automatic outs_t blank(input logic [3:0] st);
        outs_t o = '0;
        o.state = st;
        return o;
    endfunction

    task automatic push(input outs_t o, input logic mem);
        step_t s;
        s.o   = o;
        s.mem = mem;
        plan_q.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, starting at T0.
    task automatic build_plan(input logic [31:0] instr);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         alu, md, ld, st;
        outs_t      o;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        alu = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
        md  = (op == 5'd15) || (op == 5'd16);
        ld  = (op == 5'd0);
        st  = (op == 5'd2);
        plan_q.delete();
        o = blank(4'd1); o.bds = 5'd20; o.e_mar = 1'b1; o.incpc = 1'b1; push(o, 1'b0);
        o = blank(4'd2); o.rd = 1'b1; o.e_mdr = 1'b1; push(o, 1'b1);
        o = blank(4'd3); o.bds = 5'd21; o.e_ir = 1'b1; push(o, 1'b0);
        o = blank(4'd4);
        if (op == 5'd27) begin
            push(o, 1'b0);
            o = blank(4'd9); o.halted = 1'b1; push(o, 1'b0);
            return;
        end
        if (!(alu || md || ld || st)) begin
            push(o, 1'b0);
            return;
        end
        o.bds = {1'b0, rb}; o.e_y = 1'b1; push(o, 1'b0);
        o = blank(4'd5); o.e_z = 1'b1;
        if (ld || st) begin o.bds = 5'd22; o.alu_op = 5'd3; end
        else begin o.bds = {1'b0, rc}; o.alu_op = op; end
        push(o, 1'b0);
        o = blank(4'd6); o.bds = 5'd19;
        if (alu) begin o.reg_addr = ra; o.e_gp = 1'b1; push(o, 1'b0); return; end
        if (md) o.e_lo = 1'b1; else o.e_mar = 1'b1;
        push(o, 1'b0);
        o = blank(4'd7);
        if (md) begin o.bds = 5'd18; o.e_hi = 1'b1; push(o, 1'b0); return; end
        if (ld) begin o.rd = 1'b1; o.e_mdr = 1'b1; push(o, 1'b1); end
        else begin o.bds = {1'b0, ra}; o.e_mdr = 1'b1; push(o, 1'b0); end
        o = blank(4'd8);
        if (ld) begin o.bds = 5'd21; o.reg_addr = ra; o.e_gp = 1'b1; push(o, 1'b0); end
        else begin o.wr = 1'b1; push(o, 1'b1); end
    endtask

    // Called #1 after a rising edge with the DUT expected in T0.
    task automatic run_instr(input logic [31:0] instr, input int ready_delay,
                             input int max_steps, output int t6_cycles);
        step_t s;
        int    wait_cnt = 0;
        int    steps    = 0;
        logic  stall;
        bus.ir = instr;
        build_plan(instr);
        t6_cycles = 0;
        while (plan_q.size() > 0 && steps < max_steps) begin
            s = plan_q[0];
            check_val($sformatf("op%0d_st%0d", instr[31:27], s.o.state), 64'(observe()), 64'(s.o));
            if (bus.state == 4'd7) t6_cycles++;
            if (ready_delay < 0)
                bus.mem_ready = (wait_cnt >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            else
                bus.mem_ready = (wait_cnt >= ready_delay) ? 1'b1 : 1'b0;
            if (s.o.state != 4'd0 && s.o.state != 4'd9) exp_cnt++;
`ifdef MEM_WAIT_EN
            stall = s.mem && !bus.mem_ready;
`else
            stall = 1'b0;
`endif
            if (!stall) begin
                plan_q.delete(0);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            steps++;
            @(posedge clock); #1;
        end
    endtask

    task automatic kick_start();
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  ops [10];
        logic [31:0] instr;
        int          t6;
        int          exp_t6;

        ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16, 5'd26, 5'd9};

        clear = 1'b1;
        bus.start = 1'b0;
        bus.ir = 32'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("reset_outs", 64'(observe()), 64'(blank(4'd0)));
        check_val("reset_cnt", 64'(dut.cyc_cnt_q), 64'd0);
        clear = 1'b0;
        @(posedge clock); #1;
        check_val("idle_hold", 64'(bus.state), 64'd0);
        kick_start();

        run_instr(32'h18914000, -1, 100, t6);
        check_val("add_ret_state", 64'(bus.state), 64'd1);
        run_instr(32'h78228000, -1, 100, t6);

`ifdef MEM_WAIT_EN
        exp_t6 = 4;
`else
        exp_t6 = 1;
`endif
        run_instr(32'h03100010, 3, 100, t6);
        check_val("ld_t6_cycles", 64'(t6), 64'(exp_t6));
        run_instr(32'h13880004, -1, 100, t6);

        for (int i = 0; i < 40; i++) begin
            instr = {ops[$urandom_range(0, 9)], 27'($urandom)};
            run_instr(instr, -1, 100, t6);
        end
        check_val("cycle_cnt", 64'(dut.cyc_cnt_q), 64'(exp_cnt));

        // Abandon an add in T4 with an asynchronous clear.
        run_instr(32'h18914000, -1, 4, t6);
        check_val("pre_clear_state", 64'(bus.state), 64'd5);
        #2 clear = 1'b1;
        #1;
        check_val("async_clear_outs", 64'(observe()), 64'(blank(4'd0)));
        check_val("async_clear_cnt", 64'(dut.cyc_cnt_q), 64'd0);
        exp_cnt = 16'd0;
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock); #1;
        check_val("no_replay_state", 64'(bus.state), 64'd0);
        kick_start();

        run_instr(32'hD8000000, -1, 100, t6);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("halt_hold", 64'(observe()), 64'({4'd9, 26'd0, 1'b1}));
            @(posedge clock); #1;
        end
        check_val("halt_cnt_frozen", 64'(dut.cyc_cnt_q), 64'(exp_cnt));
        bus.start = 1'b0;
        #2 clear = 1'b1;
        #1;
        check_val("halt_clear", 64'(observe()), 64'(blank(4'd0)));
        @(negedge clock);
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
